// File: rtl/map_view_scan_ctrl.sv
// -----------------------------------------------------------------------------
// map_view_scan_ctrl
//
// Frame scheduler for the map pixel renderer. Each accepted start walks a
// VIEW_W x VIEW_H viewport in raster order (col fastest) and drives map_x/map_y
// to the renderer. The renderer returns rd_pix one cycle after a coordinate is
// presented. Those pixels are captured into a 2-entry FIFO and streamed to the
// writer over a valid/ready handshake. A credit rule throttles coordinate issue
// so that the FIFO can never overflow, because the renderer cannot be stalled.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   start               single-cycle frame request (ignored while busy)
//   org_x, org_y        viewport top-left map coordinate, latched on start
//   cen_x, cen_y        (MAP_VIEW_CENTER_EN only) viewport centre; the origin
//                       becomes cen - VIEW/2 clamped to the map
//   map_x, map_y        coordinate presented to the renderer
//   rd_pix              renderer pixel, valid one cycle after map_x/map_y
//   pix_data/valid/ready  RGB565 stream to the writer
//   pix_first, pix_last frame boundary tags travelling with each pixel
//   busy                frame in progress
//   done                one-cycle pulse after the final pixel is accepted
//
// Optional build macro: MAP_VIEW_CENTER_EN (centre-based origin with clamp).
// -----------------------------------------------------------------------------
module map_view_scan_ctrl #(
    parameter int VIEW_W = 240,
    parameter int VIEW_H = 240,
    parameter int MAP_W  = 320,
    parameter int MAP_H  = 240
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [8:0]  org_x,
    input  logic [8:0]  org_y,
`ifdef MAP_VIEW_CENTER_EN
    input  logic [8:0]  cen_x,
    input  logic [8:0]  cen_y,
`endif
    output logic [8:0]  map_x,
    output logic [8:0]  map_y,
    input  logic [15:0] rd_pix,
    output logic [15:0] pix_data,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        pix_first,
    output logic        pix_last,
    output logic        busy,
    output logic        done
);

    if (VIEW_W < 1 || VIEW_W > 320 || VIEW_H < 1 || VIEW_H > 240 ||
        VIEW_W > MAP_W || VIEW_H > MAP_H) begin : g_bad_cfg
        $error("map_view_scan_ctrl: viewport parameters out of range");
    end

    localparam logic [8:0] LP_COL_LAST = 9'(VIEW_W - 1);
    localparam logic [8:0] LP_ROW_LAST = 9'(VIEW_H - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DRAIN,
        S_FIN
    } state_t;

    state_t      r_state;
    logic [8:0]  r_org_x;
    logic [8:0]  r_col;
    logic [8:0]  r_row;
    logic [8:0]  r_map_x;
    logic [8:0]  r_map_y;
    logic        r_busy;
    logic        r_done;

    // Renderer latency stage: set the cycle rd_pix carries the issued pixel.
    logic        r_infl;
    logic        r_infl_first;
    logic        r_infl_last;

    // FIFO entry layout: {last, first, rgb565}.
    logic [17:0] r_mem [0:1];
    logic        r_wr_ptr;
    logic        r_rd_ptr;
    logic [1:0]  r_cnt;

    logic [17:0] w_head;
    logic        w_pop;
    logic        w_push;
    logic        w_iss;
    logic        w_col_end;
    logic        w_first;
    logic        w_last;
    logic        w_accept;
    logic [2:0]  w_occ;
    logic [8:0]  w_start_x;
    logic [8:0]  w_start_y;

`ifdef MAP_VIEW_CENTER_EN
    localparam logic signed [9:0] LP_HALF_W = 10'(VIEW_W / 2);
    localparam logic signed [9:0] LP_HALF_H = 10'(VIEW_H / 2);
    localparam logic signed [9:0] LP_MAX_X  = 10'(MAP_W - VIEW_W);
    localparam logic signed [9:0] LP_MAX_Y  = 10'(MAP_H - VIEW_H);

    // Saturate cen - half into [0, hi]; 10-bit signed covers -160..511.
    function automatic logic [8:0] clamp_org(input logic [8:0]        cen,
                                             input logic signed [9:0] half,
                                             input logic signed [9:0] hi);
        logic signed [9:0] v;
        v = $signed({1'b0, cen}) - half;
        if (v < 10'sd0)
            return 9'd0;
        else if (v > hi)
            return hi[8:0];
        else
            return v[8:0];
    endfunction

    assign w_start_x = clamp_org(cen_x, LP_HALF_W, LP_MAX_X);
    assign w_start_y = clamp_org(cen_y, LP_HALF_H, LP_MAX_Y);
`else
    assign w_start_x = org_x;
    assign w_start_y = org_y;
`endif

    assign w_head    = r_mem[r_rd_ptr];
    assign w_pop     = (r_cnt != 2'd0) && pix_ready;
    assign w_push    = r_infl;
    assign w_col_end = (r_col == LP_COL_LAST);
    assign w_first   = (r_col == 9'd0) && (r_row == 9'd0);
    assign w_last    = w_col_end && (r_row == LP_ROW_LAST);
    assign w_accept  = start && ((r_state == S_IDLE) || (r_state == S_FIN));

    // Credit: FIFO + in-flight + this issue must fit in 2 entries after
    // this cycle's pop, i.e. occupancy - pop <= 1.
    assign w_occ = {1'b0, r_cnt} + {2'b00, r_infl};
    assign w_iss = (r_state == S_SCAN) && (w_occ <= (3'd1 + {2'b00, w_pop}));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_org_x      <= 9'd0;
            r_col        <= 9'd0;
            r_row        <= 9'd0;
            r_map_x      <= 9'd0;
            r_map_y      <= 9'd0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_infl       <= 1'b0;
            r_infl_first <= 1'b0;
            r_infl_last  <= 1'b0;
            r_mem[0]     <= 18'd0;
            r_mem[1]     <= 18'd0;
            r_wr_ptr     <= 1'b0;
            r_rd_ptr     <= 1'b0;
            r_cnt        <= 2'd0;
        end else begin
            // Stage 1: renderer output captured into the FIFO
            if (w_push) begin
                r_mem[r_wr_ptr] <= {r_infl_last, r_infl_first, rd_pix};
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop)
                r_rd_ptr <= ~r_rd_ptr;
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 2'd1;
                2'b01:   r_cnt <= r_cnt - 2'd1;
                default: r_cnt <= r_cnt;
            endcase

            // Stage 0: coordinate issue, tags follow the pixel down the pipe
            r_infl       <= w_iss;
            r_infl_first <= w_iss && w_first;
            r_infl_last  <= w_iss && w_last;

            r_done <= 1'b0;
            case (r_state)
                S_IDLE, S_FIN: begin
                    if (w_accept) begin
                        r_org_x <= w_start_x;
                        r_map_x <= w_start_x;
                        r_map_y <= w_start_y;
                        r_col   <= 9'd0;
                        r_row   <= 9'd0;
                        r_busy  <= 1'b1;
                        r_state <= S_SCAN;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_SCAN: begin
                    if (w_iss) begin
                        // The final coordinate stays on map_x/map_y.
                        if (w_last) begin
                            r_state <= S_DRAIN;
                        end else if (w_col_end) begin
                            r_col   <= 9'd0;
                            r_row   <= r_row + 9'd1;
                            r_map_x <= r_org_x;
                            r_map_y <= r_map_y + 9'd1;
                        end else begin
                            r_col   <= r_col + 9'd1;
                            r_map_x <= r_map_x + 9'd1;
                        end
                    end
                end
                S_DRAIN: begin
                    // The last-tagged entry is the final push of the frame, so
                    // its acceptance means the FIFO and pipe are both empty.
                    if (w_pop && w_head[17]) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_FIN;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign map_x     = r_map_x;
    assign map_y     = r_map_y;
    assign pix_valid = (r_cnt != 2'd0);
    assign pix_data  = w_head[15:0];
    assign pix_first = pix_valid && w_head[16];
    assign pix_last  = pix_valid && w_head[17];
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
